integrate_dump: RTL

- Consumer of a tracking channel's prompt_i/prompt_q bit streams: integrate-and-dump correlator back end.
- Converts 1-bit XOR correlator outputs to ±1, accumulates over a programmable sample count or an external code-epoch pulse, and dumps signed I/Q sums to a valid/ready output register for the loop filter or host readout.
- Sits between one channel instance and the per-channel readout/loop logic. One instance per channel.

---
 rtl/gps_pkg.sv | 17 +
 rtl/sat_accum.sv | 44 ++++
 rtl/integrate_dump.sv | 114 +++++++++++
 3 files changed

// File: rtl/gps_pkg.sv
// Shared types and helpers for the tracking-channel correlator back end.
package gps_pkg;

  localparam int ACC_W_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE,
    ST_INTEGRATE
  } state_t;

  // XOR correlator bit to antipodal value: 0 -> +1, 1 -> -1.
  function automatic logic signed [1:0] bit_to_pm1(input logic b);
    return b ? -2'sd1 : 2'sd1;
  endfunction

endpackage

// File: rtl/sat_accum.sv
// Symmetric saturating +/-1 accumulator; sum already includes the same-cycle step.
module sat_accum
  import gps_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    add,
  input  logic                    bit_in,
  output logic signed [ACC_W-1:0] sum
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [1:0]       step;

  assign step = bit_to_pm1(bit_in);

  // Range is kept symmetric so +N and -N dumps stay comparable in magnitude.
  always_comb begin
    sum = acc_reg;
    if (add) begin
      if (!((step == 2'sd1 && acc_reg == ACC_MAX) ||
            (step == -2'sd1 && acc_reg == ACC_MIN))) begin
        sum = acc_reg + ACC_W'(step);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/integrate_dump.sv
// Integrate-and-dump back end: accumulates prompt I/Q over dump_len samples or
// an epoch and hands signed sums to a valid/ready output register.
module integrate_dump
  import gps_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic                    prompt_i,
  input  logic                    prompt_q,
  input  logic                    epoch,
  input  logic                    restart,
  input  logic [CNT_W-1:0]        dump_len,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_i,
  output logic signed [ACC_W-1:0] out_q,
  output logic [CNT_W-1:0]        out_count,
  output logic                    overrun,
  input  logic                    overrun_clear,
  output logic                    busy
);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W:0]   cnt_plus1;
  logic             active;
  logic             sample;
  logic             term;
  logic             dump;
  logic             acc_clear;
  logic [1:0]       arm_bit;
  logic signed [ACC_W-1:0] arm_sum [2];

  assign active    = (state_reg == ST_INTEGRATE) && enable;
  assign sample    = active && sample_valid && !restart;
  assign cnt_plus1 = {1'b0, cnt_reg} + (CNT_W + 1)'(1);
  // Wide compare: a saturated counter never matches, so only epoch can dump it.
  assign term      = sample_valid && (dump_len != '0) && (cnt_plus1 == {1'b0, dump_len});
  assign dump      = active && !restart &&
                     ((epoch && (cnt_reg != '0 || sample_valid)) || term);
  assign acc_clear = !active || restart || dump;
  assign cnt_next  = (sample && cnt_reg != '1) ? cnt_reg + CNT_W'(1) : cnt_reg;
  assign arm_bit   = {prompt_q, prompt_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_arm
      sat_accum #(.ACC_W(ACC_W)) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clear),
        .add    (sample),
        .bit_in (arm_bit[gi]),
        .sum    (arm_sum[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_count <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_reg <= ST_INTEGRATE;
            busy      <= 1'b1;
          end
        end
        ST_INTEGRATE: begin
          if (!enable) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase

      cnt_reg <= acc_clear ? '0 : cnt_next;

      // Output register stays live in IDLE so a pending dump can still drain.
      if (dump) begin
        out_valid <= 1'b1;
        out_i     <= arm_sum[0];
        out_q     <= arm_sum[1];
        out_count <= cnt_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (dump && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
